// File: rtl/hls_run_controller.sv
// -----------------------------------------------------------------------------
// hls_run_controller
//
// Sequences the start/done handshake of NUM_CH HLS accelerator instances.
// All channels are started together. A run is complete once every channel has
// reported done at least once. A sequence repeats the run cfg_runs times.
// The cycles of each run are counted from the start cycle through the
// completing cycle, inclusive. Completed runs are accumulated into a
// saturating total. If a run exceeds TIMEOUT cycles, the sequence is aborted
// and a fixed-length reset pulse is sent to the accelerators.
//
// Ports
//   clock         in   1       system clock
//   reset         in   1       asynchronous active-high reset
//   cmd_start     in   1       request to begin a sequence (accepted only when idle)
//   cfg_runs      in   RUN_W   number of runs, sampled on accepted cmd_start (0 -> 1)
//   done_port     in   NUM_CH  per-channel done pulses from the accelerators
//   start_port    out  NUM_CH  per-channel start pulses to the accelerators
//   dut_reset     out  1       accelerator reset, held RST_CYCLES cycles after a timeout
//   busy          out  1       a sequence is in progress
//   run_done      out  1       one-cycle pulse after each completed run
//   seq_done      out  1       one-cycle pulse at the end of a sequence (normal or abort)
//   timeout_flag  out  1       sticky timeout indication, cleared on the next accepted start
//   run_idx       out  RUN_W   0-based index of the current/last run
//   done_mask     out  NUM_CH  channels that have reported done in the current run
//   cycles_last   out  CNT_W   cycle count of the last completed run
//   cycles_total  out  TOT_W   saturating sum of run cycle counts in this sequence
//   cycles_min    out  CNT_W   (HLS_RUNCTL_MINMAX_EN only) shortest run in this sequence
//   cycles_max    out  CNT_W   (HLS_RUNCTL_MINMAX_EN only) longest run in this sequence
//
// Build option
//   HLS_RUNCTL_MINMAX_EN : adds the cycles_min / cycles_max tracking and ports.
// -----------------------------------------------------------------------------
module hls_run_controller #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 32,
  parameter int TOT_W      = 48,
  parameter int RUN_W      = 16,
  parameter int TIMEOUT    = 200000000,
  parameter int RST_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [RUN_W-1:0]  cfg_runs,
  input  logic [NUM_CH-1:0] done_port,
  output logic [NUM_CH-1:0] start_port,
  output logic              dut_reset,
  output logic              busy,
  output logic              run_done,
  output logic              seq_done,
  output logic              timeout_flag,
  output logic [RUN_W-1:0]  run_idx,
  output logic [NUM_CH-1:0] done_mask,
  output logic [CNT_W-1:0]  cycles_last,
  output logic [TOT_W-1:0]  cycles_total
`ifdef HLS_RUNCTL_MINMAX_EN
  ,
  output logic [CNT_W-1:0]  cycles_min,
  output logic [CNT_W-1:0]  cycles_max
`endif
);

  // The abort counter runs 0 .. RST_CYCLES-1.
  localparam int              AB_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [AB_W-1:0]  LP_AB_LAST = AB_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [RUN_W-1:0]  r_runs;
  logic [RUN_W-1:0]  r_run_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] r_mask;
  logic [CNT_W-1:0]  r_last;
  logic [TOT_W-1:0]  r_tot;
  logic              r_tflag;
  logic              r_run_done;
  logic [AB_W-1:0]   r_ab_cnt;

  logic [CNT_W-1:0]  w_cnt_now;
  logic [NUM_CH-1:0] w_mask_now;
  logic              w_complete;
  logic              w_timeout;
  logic [RUN_W:0]    w_idx_nxt;
  logic              w_more;
  logic              w_ab_last;

  // Saturating increment of the per-run cycle counter.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] a);
    return (&a) ? a : a + CNT_W'(1);
  endfunction

  // Saturating accumulate of a run count into the sequence total.
  function automatic logic [TOT_W-1:0] sat_add_tot(input logic [TOT_W-1:0] a,
                                                   input logic [CNT_W-1:0] b);
    logic [TOT_W:0] s;
    s = {1'b0, a} + (TOT_W+1)'(b);
    return s[TOT_W] ? {TOT_W{1'b1}} : s[TOT_W-1:0];
  endfunction

  // The start cycle itself counts as cycle 1. Each wait cycle adds one more.
  assign w_cnt_now  = (r_state == S_START) ? CNT_W'(1) : sat_inc_cnt(r_cnt);
  // The mask is rebuilt from scratch in the start cycle.
  assign w_mask_now = ((r_state == S_START) ? '0 : r_mask) | done_port;
  assign w_complete = ((r_state == S_START) || (r_state == S_WAIT)) && (&w_mask_now);
  // Completion in the same cycle takes priority over a timeout.
  assign w_timeout  = (r_state == S_WAIT) && (w_cnt_now == LP_TIMEOUT) && !w_complete;
  assign w_idx_nxt  = {1'b0, r_run_idx} + (RUN_W+1)'(1);
  assign w_more     = w_idx_nxt < {1'b0, r_runs};
  assign w_ab_last  = (r_ab_cnt == LP_AB_LAST);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cmd_start) w_state_nxt = S_START;
      S_START: begin
        if (w_complete) w_state_nxt = w_more ? S_START : S_DONE;
        else            w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_complete)     w_state_nxt = w_more ? S_START : S_DONE;
        else if (w_timeout) w_state_nxt = S_ABORT;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ABORT: if (w_ab_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs. These are combinational, so start_port falls as
  // soon as reset forces the state register back to idle.
  always_comb begin
    start_port = {NUM_CH{r_state == S_START}};
    dut_reset  = (r_state == S_ABORT);
    busy       = (r_state != S_IDLE);
    seq_done   = (r_state == S_DONE) || ((r_state == S_ABORT) && w_ab_last);
  end

  // Run bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_runs     <= '0;
      r_run_idx  <= '0;
      r_cnt      <= '0;
      r_mask     <= '0;
      r_last     <= '0;
      r_tot      <= '0;
      r_tflag    <= 1'b0;
      r_run_done <= 1'b0;
      r_ab_cnt   <= '0;
    end else begin
      r_run_done <= w_complete;
      case (r_state)
        S_IDLE: begin
          if (cmd_start) begin
            r_runs    <= (cfg_runs == '0) ? RUN_W'(1) : cfg_runs;
            r_run_idx <= '0;
            r_tot     <= '0;
            r_tflag   <= 1'b0;
          end
        end
        S_START, S_WAIT: begin
          r_cnt  <= w_cnt_now;
          r_mask <= w_mask_now;
          if (w_complete) begin
            r_last <= w_cnt_now;
            r_tot  <= sat_add_tot(r_tot, w_cnt_now);
            if (w_more) r_run_idx <= w_idx_nxt[RUN_W-1:0];
          end else if (w_timeout) begin
            r_tflag  <= 1'b1;
            r_ab_cnt <= '0;
          end
        end
        S_ABORT: r_ab_cnt <= r_ab_cnt + AB_W'(1);
        default: ;
      endcase
    end
  end

  assign run_done     = r_run_done;
  assign timeout_flag = r_tflag;
  assign run_idx      = r_run_idx;
  assign done_mask    = r_mask;
  assign cycles_last  = r_last;
  assign cycles_total = r_tot;

`ifdef HLS_RUNCTL_MINMAX_EN
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;

  // The minimum starts at all ones, so the first completed run always replaces it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_min <= '1;
      r_max <= '0;
    end else if ((r_state == S_IDLE) && cmd_start) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_complete) begin
      if (w_cnt_now < r_min) r_min <= w_cnt_now;
      if (w_cnt_now > r_max) r_max <= w_cnt_now;
    end
  end

  assign cycles_min = r_min;
  assign cycles_max = r_max;
`else
  // Min/max run tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_hls_run_controller.sv
module tb_hls_run_controller;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 32;
  localparam int TOT_W  = 48;
  localparam int RUN_W  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_start = 1'b0;
  logic [RUN_W-1:0]  cfg_runs = '0;
  logic [NUM_CH-1:0] done_port = '0;
  logic [NUM_CH-1:0] start_port;
  logic              dut_reset;
  logic              busy;
  logic              run_done;
  logic              seq_done;
  logic              timeout_flag;
  logic [RUN_W-1:0]  run_idx;
  logic [NUM_CH-1:0] done_mask;
  logic [CNT_W-1:0]  cycles_last;
  logic [TOT_W-1:0]  cycles_total;
`ifdef HLS_RUNCTL_MINMAX_EN
  logic [CNT_W-1:0]  cycles_min;
  logic [CNT_W-1:0]  cycles_max;
`endif

  hls_run_controller #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TOT_W(TOT_W), .RUN_W(RUN_W),
    .TIMEOUT(50), .RST_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cfg_runs(cfg_runs),
    .done_port(done_port), .start_port(start_port), .dut_reset(dut_reset),
    .busy(busy), .run_done(run_done), .seq_done(seq_done),
    .timeout_flag(timeout_flag), .run_idx(run_idx), .done_mask(done_mask),
    .cycles_last(cycles_last), .cycles_total(cycles_total)
`ifdef HLS_RUNCTL_MINMAX_EN
    , .cycles_min(cycles_min), .cycles_max(cycles_max)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int n_rd  = 0;
  int n_sd  = 0;

  // Advance one clock. Outputs are read 1 time unit after the edge, and pulse counts are kept.
  task automatic step();
    @(posedge clock);
    #1;
    if (run_done === 1'b1) n_rd++;
    if (seq_done === 1'b1) n_sd++;
  endtask

  // Request a sequence. On return, the bench is in the START cycle (cycle 0).
  task automatic start_seq(input logic [RUN_W-1:0] runs);
    n_rd = 0;
    n_sd = 0;
    cfg_runs  = runs;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || start_port !== 2'b00 || dut_reset !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: busy=%b start=%b dut_reset=%b, want 0/00/0", busy, start_port, dut_reset); end
    total++; if (run_done !== 1'b0 || seq_done !== 1'b0 || timeout_flag !== 1'b0) begin
      bad++; $display("FAIL reset_flags: run_done=%b seq_done=%b tflag=%b, want 0", run_done, seq_done, timeout_flag); end
    total++; if (run_idx !== 16'd0 || done_mask !== 2'b00 || cycles_last !== 32'd0 || cycles_total !== 48'd0) begin
      bad++; $display("FAIL reset_data: idx=%0d mask=%b last=%0d tot=%0d, want 0", run_idx, done_mask, cycles_last, cycles_total); end
`ifdef HLS_RUNCTL_MINMAX_EN
    total++; if (cycles_min !== 32'hFFFF_FFFF || cycles_max !== 32'd0) begin
      bad++; $display("FAIL reset_minmax: min=%h max=%0d, want ffffffff/0", cycles_min, cycles_max); end
`endif
    step();
    step();
    reset = 1'b0;
    done_port = 2'b11;
    step();
    step();
    done_port = 2'b00;
    total++; if (busy !== 1'b0 || done_mask !== 2'b00) begin
      bad++; $display("FAIL idle_done_ignored: busy=%b mask=%b, want 0/00", busy, done_mask); end
  endtask

  task automatic test_single_run();
    start_seq(16'd1);
    total++; if (start_port !== 2'b11 || busy !== 1'b1) begin
      bad++; $display("FAIL single_start: start=%b busy=%b, want 11/1", start_port, busy); end
    for (int c = 0; c < 16; c++) begin
      if (c == 1) begin
        total++; if (start_port !== 2'b00) begin
          bad++; $display("FAIL single_start_pulse: start=%b at cycle 1, want 00", start_port); end
      end
      if (c == 11) begin
        total++; if (done_mask !== 2'b01) begin
          bad++; $display("FAIL single_mask: mask=%b at cycle 11, want 01", done_mask); end
      end
      done_port = {(c == 15), (c == 10 || c == 12)};
      step();
    end
    done_port = 2'b00;
    total++; if (cycles_last !== 32'd16 || cycles_total !== 48'd16) begin
      bad++; $display("FAIL single_cycles: last=%0d tot=%0d, want 16/16", cycles_last, cycles_total); end
    total++; if (run_done !== 1'b1 || seq_done !== 1'b1 || run_idx !== 16'd0) begin
      bad++; $display("FAIL single_pulses: run_done=%b seq_done=%b idx=%0d, want 1/1/0", run_done, seq_done, run_idx); end
    step();
    total++; if (busy !== 1'b0 || n_rd != 1 || n_sd != 1) begin
      bad++; $display("FAIL single_end: busy=%b run_done_cnt=%0d seq_done_cnt=%0d, want 0/1/1", busy, n_rd, n_sd); end
  endtask

  task automatic test_back_to_back();
    start_seq(16'd3);
    for (int c = 0; c < 15; c++) begin
      if (c == 5) begin
        total++; if (start_port !== 2'b11 || run_idx !== 16'd1 || run_done !== 1'b1) begin
          bad++; $display("FAIL b2b_restart: start=%b idx=%0d run_done=%b, want 11/1/1", start_port, run_idx, run_done); end
      end
      done_port = (c % 5 == 4) ? 2'b11 : 2'b00;
      step();
    end
    done_port = 2'b00;
    total++; if (cycles_total !== 48'd15 || cycles_last !== 32'd5 || run_idx !== 16'd2) begin
      bad++; $display("FAIL b2b_totals: tot=%0d last=%0d idx=%0d, want 15/5/2", cycles_total, cycles_last, run_idx); end
    step();
    total++; if (n_rd != 3 || n_sd != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_counts: run_done_cnt=%0d seq_done_cnt=%0d busy=%b, want 3/1/0", n_rd, n_sd, busy); end
  endtask

  task automatic test_runs_zero();
    start_seq(16'd0);
    done_port = 2'b11;
    step();
    done_port = 2'b00;
    total++; if (cycles_last !== 32'd1 || seq_done !== 1'b1 || start_port !== 2'b00) begin
      bad++; $display("FAIL zero_runs: last=%0d seq_done=%b start=%b, want 1/1/00", cycles_last, seq_done, start_port); end
    step();
    step();
    total++; if (n_rd != 1 || n_sd != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_runs_count: run_done_cnt=%0d seq_done_cnt=%0d busy=%b, want 1/1/0", n_rd, n_sd, busy); end
  endtask

  task automatic test_timeout();
    int n_rst;
    n_rst = 0;
    start_seq(16'd1);
    for (int c = 0; c < 54; c++) begin
      if (c == 49) begin
        total++; if (timeout_flag !== 1'b0 || dut_reset !== 1'b0) begin
          bad++; $display("FAIL to_early: tflag=%b dut_reset=%b at cycle 49, want 0/0", timeout_flag, dut_reset); end
      end
      if (c == 50) begin
        total++; if (timeout_flag !== 1'b1 || dut_reset !== 1'b1 || seq_done !== 1'b0) begin
          bad++; $display("FAIL to_enter: tflag=%b dut_reset=%b seq_done=%b at cycle 50, want 1/1/0", timeout_flag, dut_reset, seq_done); end
      end
      if (c == 53) begin
        total++; if (seq_done !== 1'b1 || dut_reset !== 1'b1) begin
          bad++; $display("FAIL to_seq_done: seq_done=%b dut_reset=%b at cycle 53, want 1/1", seq_done, dut_reset); end
      end
      if (dut_reset === 1'b1) n_rst++;
      done_port = (c == 3) ? 2'b01 : 2'b00;
      step();
    end
    done_port = 2'b00;
    if (dut_reset === 1'b1) n_rst++;
    total++; if (n_rst != 4 || busy !== 1'b0 || timeout_flag !== 1'b1) begin
      bad++; $display("FAIL to_exit: dut_reset_cycles=%0d busy=%b tflag=%b, want 4/0/1", n_rst, busy, timeout_flag); end
    total++; if (cycles_last !== 32'd1 || cycles_total !== 48'd0 || n_rd != 0 || done_mask !== 2'b01) begin
      bad++; $display("FAIL to_data: last=%0d tot=%0d run_done_cnt=%0d mask=%b, want 1/0/0/01", cycles_last, cycles_total, n_rd, done_mask); end
  endtask

  task automatic test_reset_midrun();
    start_seq(16'd2);
    total++; if (timeout_flag !== 1'b0 || start_port !== 2'b11) begin
      bad++; $display("FAIL mid_restart: tflag=%b start=%b, want 0/11", timeout_flag, start_port); end
    step();
    step();
    cmd_start = 1'b1;
    cfg_runs  = 16'd5;
    step();
    cmd_start = 1'b0;
    total++; if (start_port !== 2'b00 || busy !== 1'b1 || run_idx !== 16'd0) begin
      bad++; $display("FAIL mid_cmd_ignored: start=%b busy=%b idx=%0d, want 00/1/0", start_port, busy, run_idx); end
    done_port = 2'b01;
    step();
    done_port = 2'b00;
    #1 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done_mask !== 2'b00 || cycles_last !== 32'd0 || timeout_flag !== 1'b0) begin
      bad++; $display("FAIL mid_async: busy=%b mask=%b last=%0d tflag=%b, want 0/00/0/0", busy, done_mask, cycles_last, timeout_flag); end
    step();
    reset = 1'b0;
    step();
    step();
    total++; if (start_port !== 2'b00 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_no_restart: start=%b busy=%b, want 00/0", start_port, busy); end
    start_seq(16'd1);
    #1 reset = 1'b1;
    #1;
    total++; if (start_port !== 2'b00) begin
      bad++; $display("FAIL start_async_drop: start=%b, want 00", start_port); end
    step();
    reset = 1'b0;
    step();
    total++; if (start_port !== 2'b00 || busy !== 1'b0) begin
      bad++; $display("FAIL start_no_restart: start=%b busy=%b, want 00/0", start_port, busy); end
  endtask

`ifdef HLS_RUNCTL_MINMAX_EN
  task automatic test_minmax();
    start_seq(16'd3);
    for (int c = 0; c < 21; c++) begin
      done_port = (c == 4 || c == 13 || c == 20) ? 2'b11 : 2'b00;
      step();
    end
    done_port = 2'b00;
    total++; if (cycles_min !== 32'd5 || cycles_max !== 32'd9 || cycles_last !== 32'd7 || cycles_total !== 48'd21) begin
      bad++; $display("FAIL minmax: min=%0d max=%0d last=%0d tot=%0d, want 5/9/7/21", cycles_min, cycles_max, cycles_last, cycles_total); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_run();
    test_back_to_back();
    test_runs_zero();
    test_timeout();
    test_reset_midrun();
`ifdef HLS_RUNCTL_MINMAX_EN
    test_minmax();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
